ram_arbiter: RTL and testbench



---
 rtl/coffee_bus_pkg.sv | 15 +
 rtl/ram_arbiter.sv | 98 +++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coffee_bus_pkg.sv
// Shared bus widths and the RAM arbiter state encoding.
// Imported by every block that touches the coffee RAM bus.
package coffee_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_CPU     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DMA     = 2'd2,
    ST_RESTORE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Purpose: shares one synchronous single-port RAM between a stallable CPU and bursting DMA.
// Latency: DMA grant combinational in DMA state, read data one cycle after grant; steal costs HOLD+RESTORE.
// Backpressure: CPU held via cpu_stall; DMA held by dma_gnt=0 outside DMA or once the burst limit is hit.
module ram_arbiter
  import coffee_bus_pkg::*;
#(
  parameter int BURST_MAX = 8,
  parameter int CPU_SLOTS = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [3:0]    SLOT_LIM   = 4'(CPU_SLOTS);

  arb_state_t    state_q, state_d;
  logic [3:0]    slot_cnt_q, slot_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          gnt_c;
  logic          in_dma;

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    burst_cnt_d = burst_cnt_q;
    gnt_c       = 1'b0;
    unique case (state_q)
      ST_CPU: begin
        if (slot_cnt_q < SLOT_LIM) slot_cnt_d = slot_cnt_q + 4'd1;
        if (dma_req && (slot_cnt_q >= SLOT_LIM)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d     = ST_DMA;
        burst_cnt_d = '0;
      end
      ST_DMA: begin
        gnt_c = dma_req && (burst_cnt_q < BURST_LIM);
        if (gnt_c) burst_cnt_d = burst_cnt_q + BW'(1);
        // Leave on the grant that exhausts the burst so no idle DMA cycle follows it.
        if (!dma_req || (gnt_c && (burst_cnt_q == BURST_LAST))) state_d = ST_RESTORE;
      end
      ST_RESTORE: begin
        state_d    = ST_CPU;
        slot_cnt_d = '0;
      end
      default: state_d = ST_CPU;
    endcase
    rvalid_d = gnt_c && !dma_we;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_CPU;
      slot_cnt_q  <= SLOT_LIM;
      burst_cnt_q <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Reset is folded in so a mid-burst abort stops granting in the reset cycle itself.
  assign in_dma    = nreset && (state_q == ST_DMA);
  assign dma_gnt   = nreset && gnt_c;
  assign cpu_stall = nreset && (state_q != ST_CPU);
  assign dma_rvalid = rvalid_q;

  assign ram_address = in_dma ? dma_addr  : cpu_address;
  assign ram_data    = in_dma ? dma_wdata : cpu_data;
  assign ram_wren    = in_dma ? (dma_we && dma_gnt) : cpu_wren;

  assign cpu_q     = ram_q;
  assign dma_rdata = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: instance a uses default burst of 8, instance b a burst of 1; both share inputs.
// Each instance owns a 256-word synchronous RAM model preloaded while reset is low.
module tb_ram_arbiter;

  logic        clk;
  logic        nreset;
  logic [15:0] cpu_address;
  logic [31:0] cpu_data;
  logic        cpu_wren;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [31:0] dma_wdata;

  logic [31:0] cpu_q_a, dma_rdata_a, ram_data_a, ram_q_a;
  logic [15:0] ram_address_a;
  logic        cpu_stall_a, dma_gnt_a, dma_rvalid_a, ram_wren_a;
  logic [31:0] cpu_q_b, dma_rdata_b, ram_data_b, ram_q_b;
  logic [15:0] ram_address_b;
  logic        cpu_stall_b, dma_gnt_b, dma_rvalid_b, ram_wren_b;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  int n_chk;
  int n_fail;

  ram_arbiter #(.BURST_MAX(8), .CPU_SLOTS(4)) dut_a (
    .clk(clk), .nreset(nreset),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .cpu_q(cpu_q_a), .cpu_stall(cpu_stall_a),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_a), .dma_rvalid(dma_rvalid_a), .dma_rdata(dma_rdata_a),
    .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a),
    .ram_q(ram_q_a)
  );

  ram_arbiter #(.BURST_MAX(1), .CPU_SLOTS(4)) dut_b (
    .clk(clk), .nreset(nreset),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .cpu_q(cpu_q_b), .cpu_stall(cpu_stall_b),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_b), .dma_rvalid(dma_rvalid_b), .dma_rdata(dma_rdata_b),
    .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
    .ram_q(ram_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k);
    return (k == 'h30) ? 32'h1234_5678 : 32'hA000_0000 + 32'(k);
  endfunction

  always @(posedge clk) begin
    if (!nreset) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= init_word(k);
    end else if (ram_wren_a) begin
      mem_a[ram_address_a[7:0]] <= ram_data_a;
    end
    ram_q_a <= mem_a[ram_address_a[7:0]];
  end

  always @(posedge clk) begin
    if (!nreset) begin
      for (int k = 0; k < 256; k++) mem_b[k] <= init_word(k);
    end else if (ram_wren_b) begin
      mem_b[ram_address_b[7:0]] <= ram_data_b;
    end
    ram_q_b <= mem_b[ram_address_b[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] exp_stall;
    logic [23:0] exp_gnt;
    logic        g;
    int          n_g;
    int          rd;

    n_chk  = 0;
    n_fail = 0;

    // Reset with a write request already waiting
    nreset      = 1'b0;
    cpu_address = 16'h0100;
    cpu_data    = 32'h0;
    cpu_wren    = 1'b0;
    dma_req     = 1'b1;
    dma_we      = 1'b1;
    dma_addr    = 16'h0010;
    dma_wdata   = 32'hDEAD_BEEF;
    adv(); adv(); smp();
    chk("rst_stall",   cpu_stall_a,   0);
    chk("rst_gnt",     dma_gnt_a,     0);
    chk("rst_rvalid",  dma_rvalid_a,  0);
    chk("rst_ramaddr", ram_address_a, 16'h0100);
    chk("rst_ramwren", ram_wren_a,    0);

    adv(); nreset = 1'b1; smp();
    chk("c0_stall", cpu_stall_b, 0);
    chk("c0_gnt",   dma_gnt_b,   0);
    adv(); smp();
    chk("c1_hold_stall", cpu_stall_b,   1);
    chk("c1_hold_gnt",   dma_gnt_b,     0);
    chk("c1_hold_addr",  ram_address_b, 16'h0100);
    chk("c1_hold_wren",  ram_wren_b,    0);
    adv(); smp();
    chk("c2_dma_gnt",  dma_gnt_b,     1);
    chk("c2_dma_wren", ram_wren_b,    1);
    chk("c2_dma_addr", ram_address_b, 16'h0010);
    chk("c2_dma_data", ram_data_b,    32'hDEAD_BEEF);
    adv(); dma_req = 1'b0; smp();
    chk("c3_restore_stall", cpu_stall_b,   1);
    chk("c3_restore_addr",  ram_address_b, 16'h0100);
    adv(); smp();
    chk("c4_cpu_stall", cpu_stall_b, 0);
    chk("c4_mem_write", mem_b[8'h10], 32'hDEAD_BEEF);

    // CPU-only traffic: no stall, RAM port mirrors the CPU
    for (int i = 0; i < 100; i++) begin
      adv();
      cpu_address = 16'h0080 | 16'(i % 64);
      cpu_data    = 32'(i * 7 + 1);
      cpu_wren    = i[0];
      smp();
      chk("idle_mirror", {cpu_stall_a, ram_address_a, ram_data_a, ram_wren_a},
                         {1'b0, cpu_address, cpu_data, cpu_wren});
    end

    // CPU write in the same cycle the DMA request rises
    adv();
    cpu_address = 16'h0020; cpu_data = 32'h5; cpu_wren = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0000;
    smp();
    chk("d0_stall", cpu_stall_a,   0);
    chk("d0_wren",  ram_wren_a,    1);
    chk("d0_addr",  ram_address_a, 16'h0020);
    adv(); smp();
    chk("d1_hold_stall", cpu_stall_a, 1);
    chk("d1_hold_wren",  ram_wren_a,  1);
    chk("d1_hold_data",  ram_data_a,  32'h5);
    chk("d1_hold_gnt",   dma_gnt_a,   0);
    adv(); smp();
    chk("d2_gnt",  dma_gnt_a,     1);
    chk("d2_wren", ram_wren_a,    0);
    chk("d2_addr", ram_address_a, 16'h0000);
    adv(); dma_req = 1'b0; smp();
    chk("d3_rvalid", dma_rvalid_a, 1);
    chk("d3_rdata",  dma_rdata_a,  32'hA000_0000);
    chk("d3_stall",  cpu_stall_a,  1);
    adv(); smp();
    chk("d4_restore_stall", cpu_stall_a,   1);
    chk("d4_restore_addr",  ram_address_a, 16'h0020);
    adv(); cpu_wren = 1'b0; smp();
    chk("d5_stall",    cpu_stall_a, 0);
    chk("d5_cpu_q",    cpu_q_a,     32'h5);
    chk("d5_mem_word", mem_a[8'h20], 32'h5);

    repeat (5) adv();

    // Twelve reads against an 8-deep burst: 8 grants, CPU window, then 4 more
    adv();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0000;
    exp_stall = 24'b01111111_00000111_11111110;
    exp_gnt   = 24'b00011110_00000011_11111100;
    n_g = 0;
    rd  = 0;
    for (int c = 0; c < 24; c++) begin
      smp();
      chk("burst_stall", {8'(c), 7'd0, cpu_stall_a}, {8'(c), 7'd0, exp_stall[c]});
      chk("burst_gnt",   {8'(c), 7'd0, dma_gnt_a},   {8'(c), 7'd0, exp_gnt[c]});
      if (dma_rvalid_a) begin
        chk("burst_rdata", dma_rdata_a, 32'hA000_0000 + 32'(rd));
        rd++;
      end
      g = dma_gnt_a;
      adv();
      if (g) begin
        dma_addr = dma_addr + 16'd1;
        n_g++;
        if (n_g == 12) dma_req = 1'b0;
      end
    end
    chk("burst_grants", n_g, 12);
    chk("burst_reads",  rd,  12);

    repeat (5) adv();

    // Single read granted in the last DMA cycle of a 1-deep burst
    adv(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0030; smp();
    chk("f0_stall", cpu_stall_b, 0);
    adv(); smp();
    chk("f1_hold_stall", cpu_stall_b, 1);
    chk("f1_hold_gnt",   dma_gnt_b,   0);
    adv(); smp();
    chk("f2_gnt", dma_gnt_b, 1);
    adv(); dma_req = 1'b0; smp();
    chk("f3_restore_stall", cpu_stall_b,  1);
    chk("f3_rvalid",        dma_rvalid_b, 1);
    chk("f3_rdata",         dma_rdata_b,  32'h1234_5678);
    adv(); smp();
    chk("f4_stall",  cpu_stall_b,  0);
    chk("f4_rvalid", dma_rvalid_b, 0);

    repeat (5) adv();

    // Reset pulse in the third DMA cycle of a read burst
    adv(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0000; smp();
    chk("g0_stall", cpu_stall_a, 0);
    adv(); smp();
    chk("g1_hold_stall", cpu_stall_a, 1);
    adv(); smp();
    chk("g2_gnt", dma_gnt_a, 1);
    adv(); smp();
    chk("g3_gnt", dma_gnt_a, 1);
    adv(); nreset = 1'b0; smp();
    chk("g4_rst_gnt",   dma_gnt_a,     0);
    chk("g4_rst_stall", cpu_stall_a,   0);
    chk("g4_rst_addr",  ram_address_a, 16'h0020);
    chk("g4_rst_wren",  ram_wren_a,    0);
    adv(); nreset = 1'b1; smp();
    chk("g5_stall",  cpu_stall_a,  0);
    chk("g5_gnt",    dma_gnt_a,    0);
    chk("g5_rvalid", dma_rvalid_a, 0);
    adv(); dma_req = 1'b0;
    repeat (3) adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
